// File: rtl/rom_player_pkg.sv
// Shared types and constants for the ROM sample player.
package rom_player_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] CFG_INC       = 2'd0;
  localparam logic [1:0] CFG_START     = 2'd1;
  localparam logic [1:0] CFG_END       = 2'd2;
  localparam logic [1:0] CFG_MODE_GAIN = 2'd3;

  localparam logic [1:0] MODE_LOOP     = 2'd0;
  localparam logic [1:0] MODE_ONESHOT  = 2'd1;
  localparam logic [1:0] MODE_PINGPONG = 2'd2;

endpackage

// File: rtl/rom_player_nco_btn_edge_sync.sv
// Push-button synchronizer followed by a rising-edge detector giving a
// one-cycle press pulse.
module btn_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  logic [1:0] sync_q;
  logic [1:0] edge_q;

  // Two metastability flops, then two flops for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b00;
      edge_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      edge_q <= {edge_q[0], sync_q[1]};
    end
  end

  assign press_o = edge_q[0] & ~edge_q[1];

endmodule

// File: rtl/rom_player_nco.sv
// NCO-paced ROM sample player: each accumulator carry reads one ROM word,
// scales it by the gain and strobes it out. Loop, one-shot and ping-pong.
module rom_player_nco
  import rom_player_pkg::*;
#(
  parameter int unsigned AW       = 16,
  parameter int unsigned DW       = 16,
  parameter int unsigned GW       = 8,
  parameter int unsigned OW       = 32,
  parameter int unsigned ACC_W    = 32,
  parameter int unsigned DEF_INC  = 477901,
  parameter int unsigned DEF_END  = 12586,
  parameter int unsigned DEF_GAIN = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn,
  input  logic          cmd_play,
  input  logic          cmd_stop,
  input  logic          cfg_we,
  input  logic [1:0]    cfg_addr,
  input  logic [31:0]   cfg_data,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [OW-1:0] sample_out,
  output logic          sample_vld,
  output logic          playing,
  output logic          done,
  output logic          tst
);

  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  inc_q, accum_q, accum_d;
  logic [AW-1:0]     start_q, end_q, addr_q, addr_d, loop_next_s;
  logic [1:0]        mode_q;
  logic [GW-1:0]     gain_q;
  logic              dir_up_q, dir_up_d;
  logic [OW-1:0]     sample_q;
  logic              vld_q, playing_q, done_q;
  logic              press_s, go_s, tick_s, final_s, restart_s;
  logic [ACC_W:0]    sum_s;
  logic [DW+GW-1:0]  prod_s;

  btn_edge_sync u_btn (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn),
    .press_o (press_s)
  );

  always_comb begin
    sum_s       = {1'b0, accum_q} + {1'b0, inc_q};
    tick_s      = (state_q == ST_PLAY) && sum_s[ACC_W];
    go_s        = press_s || cmd_play;
    restart_s   = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && go_s && !cmd_stop;
    prod_s      = {{GW{1'b0}}, rom_data} * {{DW{1'b0}}, gain_q};
    loop_next_s = (addr_q >= end_q) ? start_q : addr_q + ADDR_ONE;
  end

  // Address sequencing; an inverted window always behaves as a loop
  always_comb begin
    addr_d   = addr_q;
    dir_up_d = dir_up_q;
    final_s  = 1'b0;
    if (restart_s) begin
      addr_d   = start_q;
      dir_up_d = 1'b1;
    end else if (tick_s) begin
      if (end_q < start_q) begin
        addr_d = loop_next_s;
      end else begin
        case (mode_q)
          MODE_PINGPONG: begin
            if (dir_up_q) begin
              if (addr_q >= end_q) begin
                addr_d   = (start_q == end_q) ? addr_q : addr_q - ADDR_ONE;
                dir_up_d = 1'b0;
              end else begin
                addr_d = addr_q + ADDR_ONE;
              end
            end else begin
              // Single-word window stays put in both directions
              if (addr_q <= start_q) begin
                addr_d   = (start_q == end_q) ? addr_q : addr_q + ADDR_ONE;
                dir_up_d = 1'b1;
              end else begin
                addr_d = addr_q - ADDR_ONE;
              end
            end
          end
          MODE_ONESHOT: begin
            if (addr_q >= end_q) begin
              final_s = 1'b1;
            end else begin
              addr_d = addr_q + ADDR_ONE;
            end
          end
          default: addr_d = loop_next_s;
        endcase
      end
    end else begin
      addr_d = addr_q;
    end
  end

  // Player state; stop overrides any simultaneous play or press
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_PAUSE, ST_DONE: begin
        if (go_s) state_d = ST_PLAY;
        else      state_d = state_q;
      end
      ST_PLAY: begin
        if (press_s)      state_d = ST_PAUSE;
        else if (final_s) state_d = ST_DONE;
        else              state_d = ST_PLAY;
      end
      default: state_d = ST_IDLE;
    endcase
    if (cmd_stop) state_d = ST_IDLE;
    else          state_d = state_d;
  end

  always_comb begin
    if ((state_d == ST_IDLE) || (state_d == ST_DONE)) accum_d = {ACC_W{1'b0}};
    else if (state_q == ST_PLAY)                       accum_d = sum_s[ACC_W-1:0];
    else                                               accum_d = accum_q;
  end

  // Datapath and state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      accum_q   <= {ACC_W{1'b0}};
      addr_q    <= {AW{1'b0}};
      dir_up_q  <= 1'b1;
      sample_q  <= {OW{1'b0}};
      vld_q     <= 1'b0;
      playing_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      accum_q   <= accum_d;
      addr_q    <= addr_d;
      dir_up_q  <= dir_up_d;
      vld_q     <= tick_s;
      if (tick_s) sample_q <= OW'(prod_s);
      playing_q <= (state_d == ST_PLAY);
      done_q    <= (state_d == ST_DONE);
    end
  end

  // Software configuration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      inc_q   <= ACC_W'(DEF_INC);
      start_q <= {AW{1'b0}};
      end_q   <= AW'(DEF_END);
      mode_q  <= MODE_LOOP;
      gain_q  <= GW'(DEF_GAIN);
    end else if (cfg_we) begin
      case (cfg_addr)
        CFG_INC:   inc_q   <= ACC_W'(cfg_data);
        CFG_START: start_q <= AW'(cfg_data);
        CFG_END:   end_q   <= AW'(cfg_data);
        default: begin
          mode_q <= cfg_data[9:8];
          gain_q <= cfg_data[GW-1:0];
        end
      endcase
    end
  end

  assign rom_addr   = addr_q;
  assign sample_out = sample_q;
  assign sample_vld = vld_q;
  assign playing    = playing_q;
  assign done       = done_q;
  assign tst        = accum_q[ACC_W-1];

endmodule

// File: tb/tb_rom_player_nco.sv
// Self-checking bench for rom_player_nco: mode table plus hand-written
// pause, stop, window-change, reset and full-scale sequences.
module tb_rom_player_nco;
  import rom_player_pkg::*;

  localparam int AW = 16, DW = 16, GW = 8, OW = 32, ACC_W = 32;

  logic          clk = 1'b0;
  logic          rst, btn, cmd_play, cmd_stop, cfg_we, rom_ones;
  logic [1:0]    cfg_addr;
  logic [31:0]   cfg_data;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic [OW-1:0] sample_out;
  logic          sample_vld, playing, done, tst;

  always #5 clk = ~clk;

  rom_player_nco #(
    .AW(AW), .DW(DW), .GW(GW), .OW(OW), .ACC_W(ACC_W),
    .DEF_INC(477901), .DEF_END(12586), .DEF_GAIN(11)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .cmd_play(cmd_play), .cmd_stop(cmd_stop),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .rom_addr(rom_addr), .rom_data(rom_data), .sample_out(sample_out),
    .sample_vld(sample_vld), .playing(playing), .done(done), .tst(tst)
  );

  // Synchronous ROM, one cycle latency, word = address
  always @(posedge clk) rom_data <= rom_ones ? 16'hFFFF : rom_addr;

  typedef struct { logic [OW-1:0] smp; logic dn; } exp_t;
  typedef struct { logic [1:0] mode; int n; logic [OW-1:0] exp_smp [8]; } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs [3];
  int   n_checks = 0, n_fail = 0, n_seen = 0, cyc = 0, last_cyc = -1;
  bit   chk_gap = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Scoreboard: every strobe pops one expected sample
  always @(negedge clk) begin
    if (sample_vld) begin
      n_seen++;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: sample_out=%0d, scoreboard empty", sample_out);
      end else begin
        mon_e = sb_q.pop_front();
        check("sample_out", 64'(sample_out), 64'(mon_e.smp));
        check("done_with_strobe", 64'(done), 64'(mon_e.dn));
      end
      if (chk_gap && last_cyc >= 0) check("strobe_gap", 64'(cyc - last_cyc), 64'd4);
      last_cyc = cyc;
    end
  end

  task automatic push(input logic [OW-1:0] s, input logic d);
    exp_t e;
    e.smp = s;
    e.dn  = d;
    sb_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_play();
    @(negedge clk); cmd_play = 1'b1;
    @(negedge clk); cmd_play = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk); cmd_stop = 1'b1;
    @(negedge clk); cmd_stop = 1'b0;
  endtask

  // The press pulse reaches the player three edges after btn rises
  task automatic btn_press();
    @(negedge clk); btn = 1'b1;
    step(4);
    btn = 1'b0;
  endtask

  task automatic wait_seen(input int target, input int budget, input string name);
    int k = 0;
    while (n_seen < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    check(name, 64'(n_seen), 64'(target));
  endtask

  initial begin
    int base, toggles;
    logic prev_tst;

    vecs[0].mode = MODE_LOOP;     vecs[0].n = 6;
    vecs[0].exp_smp = '{32'd110, 32'd121, 32'd132, 32'd143, 32'd110, 32'd121, 32'd0, 32'd0};
    vecs[1].mode = MODE_ONESHOT;  vecs[1].n = 4;
    vecs[1].exp_smp = '{32'd110, 32'd121, 32'd132, 32'd143, 32'd0, 32'd0, 32'd0, 32'd0};
    vecs[2].mode = MODE_PINGPONG; vecs[2].n = 8;
    vecs[2].exp_smp = '{32'd110, 32'd121, 32'd132, 32'd143, 32'd132, 32'd121, 32'd110, 32'd121};

    rst = 1'b1; btn = 1'b0; cmd_play = 1'b0; cmd_stop = 1'b0;
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 32'd0; rom_ones = 1'b0;
    step(3);
    check("rst_rom_addr", 64'(rom_addr), 64'd0);
    check("rst_sample_out", 64'(sample_out), 64'd0);
    check("rst_sample_vld", 64'(sample_vld), 64'd0);
    check("rst_playing", 64'(playing), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_tst", 64'(tst), 64'd0);
    rst = 1'b0;

    cfg_write(CFG_INC, 32'h4000_0000);
    cfg_write(CFG_START, 32'd10);
    cfg_write(CFG_END, 32'd13);

    for (int i = 0; i < 3; i++) begin
      pulse_stop();
      cfg_write(CFG_MODE_GAIN, {22'd0, vecs[i].mode, 8'd11});
      for (int j = 0; j < vecs[i].n; j++)
        push(vecs[i].exp_smp[j], (vecs[i].mode == MODE_ONESHOT) && (j == vecs[i].n - 1));
      chk_gap = 1'b1; last_cyc = -1;
      base = n_seen;
      pulse_play();
      check("playing_after_cmd", 64'(playing), 64'd1);
      wait_seen(base + vecs[i].n, vecs[i].n * 4 + 20, "table_samples");
      if (vecs[i].mode == MODE_ONESHOT) begin
        step(50);
        check("oneshot_quiet", 64'(n_seen), 64'(base + 4));
        check("oneshot_done_held", 64'(done), 64'd1);
        check("oneshot_not_playing", 64'(playing), 64'd0);
        check("oneshot_addr_held", 64'(rom_addr), 64'd13);
        chk_gap = 1'b0;
        push(32'd110, 1'b0);
        btn_press();
        wait_seen(base + 5, 30, "oneshot_restart");
      end
    end

    // Pause/resume by button, then stop beating a press from IDLE
    pulse_stop();
    cfg_write(CFG_MODE_GAIN, {22'd0, MODE_LOOP, 8'd11});
    chk_gap = 1'b0;
    push(32'd110, 1'b0); push(32'd121, 1'b0);
    base = n_seen;
    pulse_play();
    wait_seen(base + 1, 20, "pause_first");
    btn_press();
    check("pause_two_samples", 64'(n_seen), 64'(base + 2));
    check("pause_not_playing", 64'(playing), 64'd0);
    toggles = 0;
    prev_tst = tst;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (tst !== prev_tst) toggles++;
      prev_tst = tst;
    end
    check("pause_tst_frozen", 64'(toggles), 64'd0);
    check("pause_no_strobes", 64'(n_seen), 64'(base + 2));
    push(32'd132, 1'b0);
    btn_press();
    wait_seen(base + 3, 20, "resume_sample");
    pulse_stop();
    step(2);
    @(negedge clk); btn = 1'b1;
    step(3);
    cmd_stop = 1'b1;
    step(1);
    cmd_stop = 1'b0; btn = 1'b0;
    step(10);
    check("stop_beats_press", 64'(playing), 64'd0);
    check("stop_no_strobes", 64'(n_seen), 64'(base + 3));

    // Shrink the window while playing, then reset mid-play
    chk_gap = 1'b1; last_cyc = -1;
    push(32'd110, 1'b0); push(32'd121, 1'b0); push(32'd132, 1'b0);
    base = n_seen;
    pulse_play();
    wait_seen(base + 3, 30, "window_before");
    cfg_write(CFG_END, 32'd11);
    push(32'd143, 1'b0); push(32'd110, 1'b0); push(32'd121, 1'b0); push(32'd110, 1'b0);
    wait_seen(base + 7, 30, "window_after");
    step(1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check("midrst_rom_addr", 64'(rom_addr), 64'd0);
    check("midrst_sample_out", 64'(sample_out), 64'd0);
    check("midrst_sample_vld", 64'(sample_vld), 64'd0);
    check("midrst_playing", 64'(playing), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_tst", 64'(tst), 64'd0);
    @(negedge clk);
    check("midrst_no_pending", 64'(n_seen), 64'(base + 7));
    rst = 1'b0;

    // Full-scale word and gain at the default rate
    chk_gap = 1'b0;
    rom_ones = 1'b1;
    cfg_write(CFG_MODE_GAIN, 32'h0000_00FF);
    push(32'h00FE_FF01, 1'b0);
    base = n_seen;
    pulse_play();
    wait_seen(base + 1, 10000, "fullscale_sample");
    pulse_stop();
    step(5);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
